// File: rtl/regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// regfile_onehot_wr
//
// Thirty-two-entry general-purpose register file for the write-back stage.
// The write port takes a one-hot select vector straight from the destination
// decoder; the decode stage reads through two combinational ports that can
// optionally forward the write data of the current cycle.
//
// Entry 0 has no storage and always reads zero. A select vector with more
// than one bit set is never written. Instead, it raises a sticky debug flag
// that stays high until err_clear is sampled or reset asserts.
//
// Parameters
//   DATA_WIDTH        width of every register and of the data ports
//   BYPASS            1: a read port whose address matches a valid write in
//                        the same cycle returns the write data
//                     0: reads always return the stored value
//
// Ports
//   clock             rising-edge clock for all state
//   ctrl_reset_n      asynchronous active-low reset; clears r1..r31 and the
//                     error flag
//   ctrl_writeEnable  global write qualifier
//   write_select      one-hot write select; bit i selects register i
//   data_writeReg     write data
//   ctrl_readRegA     read port A address
//   ctrl_readRegB     read port B address
//   data_readRegA     read port A data (combinational)
//   data_readRegB     read port B data (combinational)
//   err_clear         synchronous clear of err_multi_hot
//   err_multi_hot     sticky flag: a multi-hot write was attempted
// -----------------------------------------------------------------------------
module regfile_onehot_wr #(
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [31:0]           write_select,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [4:0]            ctrl_readRegA,
  input  logic [4:0]            ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  err_clear,
  output logic                  err_multi_hot
);

  // ---------------------------------------------------------------------------
  // Select-vector classification
  // ---------------------------------------------------------------------------
  // Clearing the lowest set bit (x & (x-1)) leaves something only when two or
  // more bits are set. This is an exact "popcount > 1" test over all 32 bits,
  // bit 0 included, without building an adder tree.
  logic [31:0] select_minus_one;
  logic        select_any;
  logic        select_multi;
  logic        select_one_hot;
  logic        wr_valid;
  logic        multi_hot_event;

  assign select_minus_one = write_select - 32'd1;
  assign select_any       = |write_select;
  assign select_multi     = |(write_select & select_minus_one);
  assign select_one_hot   = select_any && !select_multi;

  // A lone bit 0 targets the hardwired zero entry, so it is a no-op rather
  // than an error.
  assign wr_valid        = ctrl_writeEnable && select_one_hot && !write_select[0];
  assign multi_hot_event = ctrl_writeEnable && select_multi;

  // ---------------------------------------------------------------------------
  // Storage r1..r31
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs [1:31];

  // NOTE: these registers carry a reset even though they form a storage
  // array, because a cleared state after reset is part of the block's
  // contract. That keeps them in flops and out of an inferred RAM macro.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      for (int i = 1; i < 32; i++) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge
        // values; blocking here would create order-dependent simulation.
        if (write_select[i]) begin
          regs[i] <= data_writeReg;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky multi-hot error flag. Set has priority over clear, so an error
  // arriving in the clearing cycle is never lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      err_multi_hot <= 1'b0;
    end else if (multi_hot_event) begin
      err_multi_hot <= 1'b1;
    end else if (err_clear) begin
      err_multi_hot <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] stored_a;
  logic [DATA_WIDTH-1:0] stored_b;
  logic                  hit_a;
  logic                  hit_b;

  // Explicit compare-and-select over r1..r31, so address 0 falls through to
  // the zero default and the array is never indexed outside its range.
  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch
    // is inferred.
    stored_a = '0;
    stored_b = '0;
    for (int i = 1; i < 32; i++) begin
      if (ctrl_readRegA == 5'(i)) begin
        stored_a = regs[i];
      end
      if (ctrl_readRegB == 5'(i)) begin
        stored_b = regs[i];
      end
    end
  end

  // A port forwards only when this cycle carries a valid write to the
  // register it is reading. wr_valid already excludes zero-hot and multi-hot
  // cycles, and the address check keeps entry 0 at zero.
  assign hit_a = BYPASS && wr_valid && write_select[ctrl_readRegA] &&
                 (ctrl_readRegA != 5'd0);
  assign hit_b = BYPASS && wr_valid && write_select[ctrl_readRegB] &&
                 (ctrl_readRegB != 5'd0);

  assign data_readRegA = hit_a ? data_writeReg : stored_a;
  assign data_readRegB = hit_b ? data_writeReg : stored_b;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// tb_regfile_onehot_wr
//
// Drives two copies of regfile_onehot_wr, one with BYPASS=1 and one with
// BYPASS=0, from the same stimulus. A behavioural model (an array of 32
// values plus an error bit) predicts every read and the error flag.
// Inputs change on the falling edge. Reads are sampled 1 ns later, and the
// model advances on the rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_onehot_wr;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [31:0] write_select;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        err_clear;

  logic [31:0] a_byp, b_byp, a_nob, b_nob;
  logic        err_byp, err_nob;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state
  logic [31:0] model [32];
  logic        model_err;

  always #5 clock = ~clock;

  regfile_onehot_wr #(.DATA_WIDTH(32), .BYPASS(1'b1)) dut_byp (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .write_select     (write_select),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (a_byp),
    .data_readRegB    (b_byp),
    .err_clear        (err_clear),
    .err_multi_hot    (err_byp)
  );

  regfile_onehot_wr #(.DATA_WIDTH(32), .BYPASS(1'b0)) dut_nob (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .write_select     (write_select),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (a_nob),
    .data_readRegB    (b_nob),
    .err_clear        (err_clear),
    .err_multi_hot    (err_nob)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit model_wr_valid();
    return ctrl_writeEnable && ($countones(write_select) == 1) && !write_select[0];
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
    if (addr == 5'd0) return 32'h0;
    if (byp && model_wr_valid() && write_select[addr]) return data_writeReg;
    return model[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_err = 1'b0;
  endtask

  task automatic model_edge();
    if (model_wr_valid()) begin
      for (int i = 1; i < 32; i++)
        if (write_select[i]) model[i] = data_writeReg;
    end
    if (ctrl_writeEnable && $countones(write_select) > 1) model_err = 1'b1;
    else if (err_clear) model_err = 1'b0;
  endtask

  // One rising edge with model update, ending on the next falling edge.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic drive(input logic we, input logic [31:0] ws, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    ctrl_writeEnable = we;
    write_select     = ws;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    err_clear        = clr;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    drive(1'b0, 32'h0, 32'h0, ra, rb, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] e;
    ctrl_reset_n = 1'b0;
    model_reset();
    idle(5'd0, 5'd0);
    #12;
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      e = exp_read(ctrl_readRegA, 1'b1);
      vectors++;
      if (a_byp !== e) begin miscompares++; $display("FAIL reset_rd_a_byp addr=%0d got=%h exp=%h", i, a_byp, e); end
      vectors++;
      if (a_nob !== e) begin miscompares++; $display("FAIL reset_rd_a_nob addr=%0d got=%h exp=%h", i, a_nob, e); end
      e = exp_read(ctrl_readRegB, 1'b1);
      vectors++;
      if (b_byp !== e) begin miscompares++; $display("FAIL reset_rd_b_byp addr=%0d got=%h exp=%h", 31 - i, b_byp, e); end
      vectors++;
      if (b_nob !== e) begin miscompares++; $display("FAIL reset_rd_b_nob addr=%0d got=%h exp=%h", 31 - i, b_nob, e); end
    end
    vectors++;
    if (err_byp !== 1'b0 || err_nob !== 1'b0) begin
      miscompares++; $display("FAIL reset_err got=%b/%b exp=0", err_byp, err_nob);
    end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    // A write aimed at r0 only: no storage, no error.
    drive(1'b1, 32'h1, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
    #1;
    vectors++;
    if (a_byp !== 32'h0 || b_byp !== 32'h0) begin
      miscompares++; $display("FAIL r0_bypass got=%h/%h exp=0", a_byp, b_byp);
    end
    cycle();
    idle(5'd0, 5'd0);
    #1;
    vectors++;
    if (a_byp !== 32'h0 || a_nob !== 32'h0 || err_byp !== 1'b0 || err_nob !== 1'b0) begin
      miscompares++; $display("FAIL r0_write got=%h/%h err=%b/%b exp=0", a_byp, a_nob, err_byp, err_nob);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 32'h0000_0020, 32'hA5A5_0001, 5'd0, 5'd0, 1'b0);
    cycle();
    idle(5'd5, 5'd5);
    #1;
    vectors++;
    if (a_nob !== 32'hA5A5_0001 || b_nob !== 32'hA5A5_0001 || a_byp !== 32'hA5A5_0001 || b_byp !== 32'hA5A5_0001) begin
      miscompares++; $display("FAIL write_r5 got=%h/%h/%h/%h exp=a5a50001", a_byp, b_byp, a_nob, b_nob);
    end
    ctrl_readRegA = 5'd4;
    ctrl_readRegB = 5'd6;
    #1;
    vectors++;
    if (a_nob !== model[4] || b_nob !== model[6]) begin
      miscompares++; $display("FAIL neighbours got=%h/%h exp=%h/%h", a_nob, b_nob, model[4], model[6]);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h0000_0008, 32'h0303_0303, 5'd0, 5'd0, 1'b0);
    cycle();
    drive(1'b1, 32'h0000_0080, 32'h7777_0007, 5'd0, 5'd0, 1'b0);
    cycle();
    drive(1'b1, 32'h0000_0080, 32'h1234_5678, 5'd7, 5'd3, 1'b0);
    #1;
    vectors++;
    if (a_byp !== 32'h1234_5678) begin miscompares++; $display("FAIL bypass_a got=%h exp=12345678", a_byp); end
    vectors++;
    if (b_byp !== 32'h0303_0303) begin miscompares++; $display("FAIL bypass_b_other got=%h exp=03030303", b_byp); end
    vectors++;
    if (a_nob !== 32'h7777_0007) begin miscompares++; $display("FAIL nobypass_old got=%h exp=77770007", a_nob); end
    cycle();
    idle(5'd7, 5'd7);
    #1;
    vectors++;
    if (a_nob !== 32'h1234_5678 || b_byp !== 32'h1234_5678) begin
      miscompares++; $display("FAIL nobypass_next got=%h/%h exp=12345678", a_nob, b_byp);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0000_0400, 32'h0000_AAAA, 5'd10, 5'd10, 1'b0);
    cycle();
    drive(1'b1, 32'h0000_0400, 32'h0000_BBBB, 5'd10, 5'd10, 1'b0);
    #1;
    vectors++;
    if (a_byp !== 32'h0000_BBBB || b_byp !== 32'h0000_BBBB || a_nob !== 32'h0000_AAAA) begin
      miscompares++; $display("FAIL b2b_bypass got=%h/%h/%h exp=bbbb/bbbb/aaaa", a_byp, b_byp, a_nob);
    end
    cycle();
    idle(5'd10, 5'd0);
    #1;
    vectors++;
    if (a_nob !== 32'h0000_BBBB) begin miscompares++; $display("FAIL b2b_last_wins got=%h exp=0000bbbb", a_nob); end
  endtask

  task automatic test_multi_hot();
    drive(1'b1, 32'h0000_0100, 32'h0000_0088, 5'd0, 5'd0, 1'b0);
    cycle();
    drive(1'b1, 32'h0000_0200, 32'h0000_0099, 5'd0, 5'd0, 1'b0);
    cycle();
    drive(1'b1, 32'h0000_0300, 32'hFFFF_FFFF, 5'd8, 5'd9, 1'b0);
    #1;
    vectors++;
    if (a_byp !== 32'h0000_0088 || b_byp !== 32'h0000_0099) begin
      miscompares++; $display("FAIL multi_no_bypass got=%h/%h exp=88/99", a_byp, b_byp);
    end
    vectors++;
    if (err_byp !== 1'b0) begin miscompares++; $display("FAIL multi_err_early got=%b exp=0", err_byp); end
    cycle();
    idle(5'd8, 5'd9);
    #1;
    vectors++;
    if (a_nob !== 32'h0000_0088 || b_nob !== 32'h0000_0099) begin
      miscompares++; $display("FAIL multi_no_write got=%h/%h exp=88/99", a_nob, b_nob);
    end
    vectors++;
    if (err_byp !== model_err || err_nob !== model_err) begin
      miscompares++; $display("FAIL multi_err_set got=%b/%b exp=%b", err_byp, err_nob, model_err);
    end
    drive(1'b0, 32'h0000_0300, 32'hFFFF_FFFF, 5'd8, 5'd9, 1'b0);
    cycle();
    #1;
    vectors++;
    if (err_byp !== 1'b1 || a_nob !== 32'h0000_0088) begin
      miscompares++; $display("FAIL multi_en_low got err=%b r8=%h exp err=1 r8=88", err_byp, a_nob);
    end
  endtask

  task automatic test_err_clear();
    // Bit 0 counts: r0 plus r1 is multi-hot.
    drive(1'b1, 32'h0000_0003, 32'h0000_5555, 5'd1, 5'd0, 1'b1);
    cycle();
    idle(5'd1, 5'd0);
    #1;
    vectors++;
    if (err_byp !== 1'b1 || err_nob !== 1'b1) begin
      miscompares++; $display("FAIL set_beats_clear got=%b/%b exp=1", err_byp, err_nob);
    end
    vectors++;
    if (a_nob !== model[1]) begin miscompares++; $display("FAIL bit0_multi_no_write got=%h exp=%h", a_nob, model[1]); end
    err_clear = 1'b1;
    #1;
    vectors++;
    if (err_byp !== 1'b1) begin miscompares++; $display("FAIL clear_sync got=%b exp=1", err_byp); end
    cycle();
    err_clear = 1'b0;
    #1;
    vectors++;
    if (err_byp !== 1'b0 || err_nob !== 1'b0) begin
      miscompares++; $display("FAIL clear got=%b/%b exp=0", err_byp, err_nob);
    end
    drive(1'b0, 32'hF000_000F, 32'h1, 5'd0, 5'd0, 1'b0);
    cycle();
    #1;
    vectors++;
    if (err_byp !== 1'b0) begin miscompares++; $display("FAIL en_low_no_set got=%b exp=0", err_byp); end
    drive(1'b1, 32'h0, 32'h1, 5'd0, 5'd0, 1'b0);
    cycle();
    #1;
    vectors++;
    if (err_byp !== 1'b0) begin miscompares++; $display("FAIL zero_hot_no_set got=%b exp=0", err_byp); end
  endtask

  task automatic test_random();
    logic [31:0] ws;
    logic [31:0] e;
    int          kind;
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 6)       ws = 32'h1 << $urandom_range(0, 31);
      else if (kind == 6) ws = 32'h0;
      else                ws = $urandom() | (32'h1 << $urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), ws, $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 7) == 0));
      // Aim a read at the write target half the time to exercise bypass.
      if (kind < 6 && $urandom_range(0, 1) == 1) ctrl_readRegA = 5'($clog2(ws));
      #1;
      e = exp_read(ctrl_readRegA, 1'b1);
      vectors++;
      if (a_byp !== e) begin miscompares++; $display("FAIL rand_a_byp n=%0d got=%h exp=%h", n, a_byp, e); end
      e = exp_read(ctrl_readRegB, 1'b1);
      vectors++;
      if (b_byp !== e) begin miscompares++; $display("FAIL rand_b_byp n=%0d got=%h exp=%h", n, b_byp, e); end
      e = exp_read(ctrl_readRegA, 1'b0);
      vectors++;
      if (a_nob !== e) begin miscompares++; $display("FAIL rand_a_nob n=%0d got=%h exp=%h", n, a_nob, e); end
      e = exp_read(ctrl_readRegB, 1'b0);
      vectors++;
      if (b_nob !== e) begin miscompares++; $display("FAIL rand_b_nob n=%0d got=%h exp=%h", n, b_nob, e); end
      cycle();
      vectors++;
      if (err_byp !== model_err || err_nob !== model_err) begin
        miscompares++; $display("FAIL rand_err n=%0d got=%b/%b exp=%b", n, err_byp, err_nob, model_err);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 32'h1 << i, 32'hC0DE_0000 | 32'(i), 5'd0, 5'd0, 1'b0);
      cycle();
    end
    idle(5'd17, 5'd31);
    #1;
    vectors++;
    if (a_nob !== 32'hC0DE_0011 || b_nob !== 32'hC0DE_001F) begin
      miscompares++; $display("FAIL fill got=%h/%h exp=c0de0011/c0de001f", a_nob, b_nob);
    end
    // A write is pending when reset drops between edges; it must be lost.
    drive(1'b1, 32'h0010_0000, 32'h2020_2020, 5'd0, 5'd0, 1'b0);
    #2;
    ctrl_reset_n = 1'b0;
    model_reset();
    idle(5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(i);
      #1;
      vectors++;
      if (a_byp !== 32'h0 || b_byp !== 32'h0 || a_nob !== 32'h0 || b_nob !== 32'h0) begin
        miscompares++; $display("FAIL async_reset addr=%0d got=%h/%h/%h/%h exp=0", i, a_byp, b_byp, a_nob, b_nob);
      end
    end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'h0000_0031, 5'd0, 5'd0, 1'b0);
    cycle();
    idle(5'd31, 5'd20);
    #1;
    vectors++;
    if (a_nob !== 32'h0000_0031 || a_byp !== 32'h0000_0031) begin
      miscompares++; $display("FAIL first_write got=%h/%h exp=00000031", a_nob, a_byp);
    end
    vectors++;
    if (b_nob !== 32'h0) begin miscompares++; $display("FAIL lost_write got=%h exp=0", b_nob); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_multi_hot();
    test_err_clear();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_onehot_wr.md
# regfile_onehot_wr

Thirty-two-entry general-purpose register file whose write port is driven by a one-hot write-select vector. The vector comes from the write-back destination decoder (5-bit destination register, gated by write enable). The block sits directly downstream of that decoder in the write-back stage. It serves the decode stage through two combinational read ports with optional same-cycle write-through bypass. Entry 0 is hardwired to zero. Multi-hot select vectors are detected, blocked, and latched as a sticky error for debug.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- BYPASS, 1, 1 = a read port returns write data when the read address matches a valid write in the same cycle; 0 = a read returns only the stored value

Ports:
- clock  input  1  rising-edge clock for all state
- ctrl_reset_n  input  1  reset, asynchronous assert, active-low; clears all registers and the error flag
- ctrl_writeEnable  input  1  global write qualifier
- write_select  input  32  one-hot write select; bit i selects register i
- data_writeReg  input  DATA_WIDTH  write data
- ctrl_readRegA  input  5  read port A address
- ctrl_readRegB  input  5  read port B address
- data_readRegA  output  DATA_WIDTH  read port A data
- data_readRegB  output  DATA_WIDTH  read port B data
- err_clear  input  1  synchronous clear of err_multi_hot
- err_multi_hot  output  1  sticky flag: a multi-hot write was attempted

## Operation
- Storage: registers r1..r31, each DATA_WIDTH bits. r0 has no storage and always reads 0.
- Write validity: wr_valid = ctrl_writeEnable AND popcount(write_select) == 1 AND write_select[0] == 0.
- Valid write: the register selected by write_select takes data_writeReg at the rising clock edge.
- Zero-hot select with enable high: no write, no error.
- write_select == 32'h1 (r0 only): no write, no error.
- Multi-hot select with enable high: no register is written, including any subset of the selected registers. err_multi_hot sets at that edge.
  - popcount counts all 32 bits, bit 0 included.
  - A multi-hot select with enable low is ignored and does not set the error.
- err_multi_hot is sticky until err_clear is sampled high or reset asserts.
  - A new multi-hot event and err_clear in the same cycle: set wins, flag stays 1.
- Read ports are independent and combinational. Address 0 returns 0 on both ports, regardless of bypass.
- Bypass (BYPASS=1): if wr_valid and write_select[addr] == 1 and addr != 0, the port outputs data_writeReg. Otherwise it outputs the stored value.
  - Both ports may bypass the same write at once.
  - Bypass never occurs on a multi-hot or zero-hot cycle.
- BYPASS=0: a read in the write cycle returns the old value. The new value is visible from the next cycle.

## Timing
- Reset: while ctrl_reset_n is low, r1..r31 = 0, err_multi_hot = 0, and both read outputs = 0 (combinational from the cleared state).
  - Reset asserted mid-write: the write is lost and all registers are 0.
  - A write on the first rising edge after deassertion is honoured.
- Write latency: one edge. Data sampled at edge N is stored value from edge N onward.
- Read latency: zero cycles (combinational from addresses, state and, with bypass, write inputs).
- Error latency: err_multi_hot rises after the edge that sampled the bad select. Clear takes effect at the edge that samples err_clear.
- No handshake. The block accepts one write per cycle unconditionally and never stalls.
- Back-to-back writes to the same register: last write wins. The bypass returns the current cycle's data.

## Test plan
- Reset then read all 32 addresses on both ports → every value 0, err_multi_hot = 0. Writing 32'hDEADBEEF with write_select = 32'h1 → r0 still reads 0, no error.
- Write 32'hA5A5_0001 with write_select = 32'h0000_0020 (r5), then read A=5, B=5 next cycle → both 32'hA5A5_0001. Neighbouring r4 and r6 remain 0.
- BYPASS=1: same cycle, write r7 = 32'h1234_5678 with read A=7, B=3 → A = 32'h1234_5678, B = old r3. Repeat with BYPASS=0 → A = old r7 that cycle, new value the next cycle.
- Write with write_select = 32'h0000_0300 (r8 and r9) and data 32'hFFFF_FFFF → r8 and r9 unchanged, err_multi_hot = 1 from the next cycle. Same select with enable low → flag unchanged.
- err_clear high in the same cycle as another multi-hot write → flag stays 1. err_clear alone on a later cycle → flag 0 at the next edge.
- Fill r1..r31 with distinct values, then pulse ctrl_reset_n low asynchronously between edges → all reads 0 immediately. The first post-reset write to r31 = 32'h0000_0031 is read back correctly.
